dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port word-addressed data memory between two requesters: the CPU load/store stage and a DMA/debug loader.
- One transaction is in flight at a time. The CPU has fixed priority, with an anti-starvation counter for DMA.
- Drives the memory's read enable, write enable, address and write data. Captures read data and returns it with a one-cycle ack pulse.

Parameters:
- DATA_WIDTH, 32, width of write data and read data.
- MEM_WORDS, 1024, memory depth in words; mem_addr is forwarded unmodified.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which DMA wins; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset, sampled on posedge clock.
- cpu_req  in  1  CPU request; held with addr/we/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read result; valid while cpu_ack is high, then held.
- cpu_err  out  1  alignment error, qualified by cpu_ack (see Optional Feature).
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata, dma_err: same as the cpu_* ports, for the DMA requester.
- mem_addr  out  32  address to memory.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory registered read result; valid one cycle after mem_re, and 0 otherwise.

Behaviour:
- Reset (reset low at posedge):
  - state = IDLE; owner cleared; starve_cnt = 0.
  - All outputs 0: acks, errs, mem_re, mem_we, mem_addr, mem_wdata, both rdata registers.
  - A transaction in progress is abandoned with no ack and no further memory strobes.
  - A write already strobed into memory is not undone.
- FSM states: IDLE, ACCESS, LATCH, ACK.
- IDLE:
  - Arbitrate on sampled requests; no request means stay in IDLE.
  - Only one requester -> grant it.
  - Both requesting -> grant DMA if starve_cnt == STARVE_LIMIT, else grant CPU.
  - On grant, register owner, address, we and wdata, then go to ACCESS.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when both request and CPU wins.
  - Clears to 0 on any DMA grant.
  - Otherwise unchanged.
- ACCESS: for exactly one cycle, mem_addr/mem_wdata = latched values; mem_we = latched we; mem_re = !latched we. Next state LATCH.
- LATCH: mem_re = mem_we = 0. For a read, mem_rdata is captured into the owner's rdata register at the end of this cycle. Next state ACK.
- ACK:
  - Owner's ack = 1 for exactly this cycle; the other ack stays 0.
  - rdata is updated only by reads; writes leave it unchanged.
  - Next state IDLE.
- Latency: request sampled in IDLE at cycle N -> ack in cycle N+3.
  - Back-to-back transactions from one requester issue every 4 cycles (req held high through ack is treated as a new request in the following IDLE).
- Requests arriving while not in IDLE wait; requests are never dropped.
- A requester that deasserts req before its ack still completes and receives its ack.
- mem_addr and mem_wdata are held at their last values outside ACCESS; only the strobes are qualified.
- A change on the non-owner's inputs during a transaction has no effect.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - A granted request with addr[1:0] != 0 skips ACCESS and LATCH and goes IDLE -> ACK.
  - The ack is returned with the owner's err = 1.
  - No memory strobe, and rdata is unchanged.
  - Latency is N+1.
  - starve_cnt is updated as for a normal grant.
- Undefined:
  - addr[1:0] is ignored; every request takes the full path.
  - cpu_err and dma_err are tied to 0.

Test Plan:
- Reset, then CPU write addr 0x10 data 0xDEADBEEF, then CPU read 0x10 -> mem_we high for exactly one cycle; read ack at N+3 with cpu_rdata = 0xDEADBEEF; dma_ack never asserted.
- cpu_req and dma_req both held continuously with STARVE_LIMIT = 4 -> grant order CPU, CPU, CPU, CPU, DMA, repeating; starve_cnt returns to 0 after each DMA grant.
- DMA write 0x20 = 0x12345678 while CPU idle, then CPU read 0x20 -> cpu_rdata = 0x12345678; dma_rdata unchanged (0).
- reset driven low during LATCH of a CPU read -> no cpu_ack; all outputs 0 next cycle; a subsequent read of the same address completes normally at N+3.
- CPU req raised one cycle after a DMA grant -> CPU waits; cpu_ack arrives 4 cycles after dma_ack.
- With DMEM_ARB_ALIGN_CHECK_EN: CPU read at 0x13 -> cpu_ack and cpu_err at N+1; mem_re and mem_we stay 0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and a DMA/debug loader, one transaction at a time.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned requests with an err-qualified ack and no memory access.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [31:0]           dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_err,

    output logic [31:0]           mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || MEM_WORDS < 1) begin : g_param_check
        $error("dmem_arbiter: STARVE_LIMIT must be 1..15 and MEM_WORDS positive");
    end

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        LATCH,
        ACK
    } state_t;

    state_t                state;
    logic                  owner_dma;
    logic                  lat_we;
    logic [3:0]            starve_cnt;

    logic                  any_req;
    logic                  grant_dma;
    logic                  sel_we;
    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [3:0]            starve_next;
    logic                  misaligned;

    // CPU wins ties unless DMA has already lost STARVE_LIMIT arbitrations in a row.
    always_comb begin
        any_req     = cpu_req | dma_req;
        grant_dma   = dma_req && (!cpu_req || (starve_cnt == LIMIT));
        sel_we      = grant_dma ? dma_we    : cpu_we;
        sel_addr    = grant_dma ? dma_addr  : cpu_addr;
        sel_wdata   = grant_dma ? dma_wdata : cpu_wdata;
        starve_next = starve_cnt;
        if (grant_dma) begin
            starve_next = 4'd0;
        end else if (cpu_req && dma_req && (starve_cnt != LIMIT)) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign misaligned = (sel_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
    assign cpu_err    = 1'b0;
    assign dma_err    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner_dma  <= 1'b0;
            lat_we     <= 1'b0;
            starve_cnt <= 4'd0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            mem_addr   <= 32'd0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            cpu_err    <= 1'b0;
            dma_err    <= 1'b0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            cpu_err <= 1'b0;
            dma_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_dma  <= grant_dma;
                        lat_we     <= sel_we;
                        starve_cnt <= starve_next;
                        if (misaligned) begin
                            // Rejected requests bypass the memory entirely and ack next cycle.
                            cpu_ack <= !grant_dma;
                            dma_ack <= grant_dma;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                            cpu_err <= !grant_dma;
                            dma_err <= grant_dma;
`endif
                            state   <= ACK;
                        end else begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_we    <= sel_we;
                            mem_re    <= !sel_we;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state <= LATCH;
                end
                LATCH: begin
                    // The memory returns read data one cycle after the strobe, i.e. during this state.
                    if (!lat_we) begin
                        if (owner_dma) begin
                            dma_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                    cpu_ack <= !owner_dma;
                    dma_ack <= owner_dma;
                    state   <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
